// File: rtl/id_pipe_pkg.sv
// -----------------------------------------------------------------------------
// id_pipe_pkg
// Shared definitions for the ID-stage scoreboard/forwarding slice.
//   FWD_SEL_RF  : operand-select code meaning "take the register file value"
//   LW_DEF      : default latency counter width
//   AW_DEF      : default register address width
//   reg_addr_t  : register address type at the default width
//   fwd_sel_w() : width of an operand select for a given number of sources
// -----------------------------------------------------------------------------
package id_pipe_pkg;

    localparam int FWD_SEL_RF = 0;
    localparam int LW_DEF     = 3;
    localparam int AW_DEF     = 5;

    typedef logic [AW_DEF-1:0] reg_addr_t;

    // Select code 0 is the register file, codes 1..nfwd are the sources.
    function automatic int fwd_sel_w(input int nfwd);
        return $clog2(nfwd + 1);
    endfunction

endpackage

// File: rtl/sb_reg_counter.sv
// -----------------------------------------------------------------------------
// sb_reg_counter
// Pending-latency down-counter for one architectural register.
// Ports:
//   clk   : clock
//   reset : asynchronous active-low clear
//   flush : synchronous clear (pipeline redirect), wins over load
//   load  : accepted issue writing this register
//   lat   : producer latency to load
//   cnt   : current remaining stall cycles (registered)
// -----------------------------------------------------------------------------
module sb_reg_counter
    import id_pipe_pkg::*;
#(
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          load,
    input  logic [LW-1:0] lat,
    output logic [LW-1:0] cnt
);

    logic [LW-1:0] cnt_r;
    logic [LW-1:0] dec_s;
    logic [LW-1:0] cnt_next_s;

    // Next count: flush clears, a load keeps the larger of the new latency and
    // the decremented old value (an older, slower producer still in flight
    // must not be shortened), otherwise count down towards zero.
    always_comb begin
        dec_s      = (cnt_r != '0) ? (cnt_r - LW'(1)) : '0;
        cnt_next_s = dec_s;
        if (flush) begin
            cnt_next_s = '0;
        end else if (load) begin
            cnt_next_s = (lat > dec_s) ? lat : dec_s;
        end else begin
            cnt_next_s = dec_s;
        end
    end

    // Counter state with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/id_scoreboard_fwd.sv
// -----------------------------------------------------------------------------
// id_scoreboard_fwd
// ID-stage hazard scoreboard and operand forwarding, one per register file.
// A per-register latency counter stalls consumers for exactly as long as a
// multi-cycle producer needs; operands are taken from the youngest matching
// forwarding source or, failing that, the register file.
// Ports:
//   clk, reset (async active-low)
//   issue_valid, flush, rs, rt, rs_used, rt_used, rd_wr, rd, rd_lat : ID info
//   fwd_valid/fwd_rw/fwd_data : NFWD forwarding sources, index 0 youngest
//   rf_a, rf_b    : register file read data
//   op_a, op_b    : selected operands (combinational)
//   sel_a, sel_b  : 0 = register file, k+1 = source k (combinational)
//   stall         : hold PC and IF/ID, bubble into ID/EX (combinational)
//   pending       : bit r set while register r has a nonzero counter
//   stall_cycles  : stall statistics counter
// Build option: define ID_SB_STATS_EN to implement stall_cycles; otherwise it
// reads as zero and no counter flops exist.
// -----------------------------------------------------------------------------
module id_scoreboard_fwd
    import id_pipe_pkg::*;
#(
    parameter  int NREGS = 32,
    parameter  int AW    = 5,
    parameter  int DW    = 32,
    parameter  int NFWD  = 2,
    parameter  int LW    = LW_DEF,
    localparam int SW    = fwd_sel_w(NFWD)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               issue_valid,
    input  logic               flush,
    input  logic [AW-1:0]      rs,
    input  logic [AW-1:0]      rt,
    input  logic               rs_used,
    input  logic               rt_used,
    input  logic               rd_wr,
    input  logic [AW-1:0]      rd,
    input  logic [LW-1:0]      rd_lat,
    input  logic [NFWD-1:0]    fwd_valid,
    input  logic [NFWD*AW-1:0] fwd_rw,
    input  logic [NFWD*DW-1:0] fwd_data,
    input  logic [DW-1:0]      rf_a,
    input  logic [DW-1:0]      rf_b,
    output logic [DW-1:0]      op_a,
    output logic [DW-1:0]      op_b,
    output logic [SW-1:0]      sel_a,
    output logic [SW-1:0]      sel_b,
    output logic               stall,
    output logic [NREGS-1:0]   pending,
    output logic [31:0]        stall_cycles
);

    logic [NREGS-1:0][LW-1:0] cnt_s;
    logic [NREGS-1:0]         pending_s;
    logic                     hit_a_s;
    logic                     hit_b_s;
    logic                     stall_s;
    logic                     load_s;
    logic [SW-1:0]            sel_a_s;
    logic [SW-1:0]            sel_b_s;
    logic [DW-1:0]            op_a_s;
    logic [DW-1:0]            op_b_s;

    // Register 0 is hardwired zero and never becomes pending.
    assign cnt_s[0] = '0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        sb_reg_counter #(
            .LW (LW)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .load  (load_s && (rd == AW'(r))),
            .lat   (rd_lat),
            .cnt   (cnt_s[r])
        );
    end

    // Hazard detection on pre-update counters; a flush cycle never stalls.
    always_comb begin
        hit_a_s = rs_used && (rs != '0) && (cnt_s[rs] != '0);
        hit_b_s = rt_used && (rt != '0) && (cnt_s[rt] != '0);
        stall_s = issue_valid && !flush && (hit_a_s || hit_b_s);
        load_s  = issue_valid && !stall_s && !flush && rd_wr && (rd != '0);
    end

    // Pending bitmap straight from the counters.
    always_comb begin
        pending_s = '0;
        for (int r = 0; r < NREGS; r++) begin
            pending_s[r] = (cnt_s[r] != '0);
        end
    end

    // Forwarding priority mux: scan oldest to youngest so the lowest matching
    // index (youngest result) is the one left standing.
    always_comb begin
        sel_a_s = SW'(FWD_SEL_RF);
        sel_b_s = SW'(FWD_SEL_RF);
        op_a_s  = rf_a;
        op_b_s  = rf_b;
        for (int k = NFWD - 1; k >= 0; k--) begin
            sel_a_s = (fwd_valid[k] && (fwd_rw[k*AW +: AW] == rs) && (rs != '0))
                      ? SW'(k + 1) : sel_a_s;
            op_a_s  = (fwd_valid[k] && (fwd_rw[k*AW +: AW] == rs) && (rs != '0))
                      ? fwd_data[k*DW +: DW] : op_a_s;
            sel_b_s = (fwd_valid[k] && (fwd_rw[k*AW +: AW] == rt) && (rt != '0))
                      ? SW'(k + 1) : sel_b_s;
            op_b_s  = (fwd_valid[k] && (fwd_rw[k*AW +: AW] == rt) && (rt != '0))
                      ? fwd_data[k*DW +: DW] : op_b_s;
        end
    end

    assign stall   = stall_s;
    assign pending = pending_s;
    assign sel_a   = sel_a_s;
    assign sel_b   = sel_b_s;
    assign op_a    = op_a_s;
    assign op_b    = op_b_s;

`ifdef ID_SB_STATS_EN
    logic [31:0] stall_cycles_r;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_r <= 32'd0;
        end else if (stall_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign stall_cycles = stall_cycles_r;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
